ifetch_mem_port: RTL and testbench
==================================

// Module: ifetch_mem_port
// PURPOSE
//  Memory-side responder for the instruction-fetch request interface.
//  Accepts a word request (req/addr) from the fetch stage and reads 4 bytes over the shared byte-wide RAM bus.
//  Assembles the bytes little-endian and returns the word with a 1-cycle ins_vld pulse.
//  Sits between the fetch stage and the top-level RAM/bus arbiter; aborts on branch/jump flush.
// PARAMETERS
//  ADDR_W        32   byte-address width of the request and of mem_a
//  ICACHE_LINES  64   lines in the optional I-cache (power of 2, one 32-bit word per line)
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset: synchronous, active-high
//  rdy        in   1       global ready; low freezes all state and outputs
//  req        in   1       fetch request; held high with addr stable until ins_vld
//  addr       in   ADDR_W  word address of instruction; addr[1:0] must be 0
//  flush      in   1       jump/branch redirect: abort the request in flight
//  bus_gnt    in   1       arbiter grant of the RAM bus to this port
//  mem_din    in   8       RAM read byte for the address driven in the previous cycle
//  bus_req    out  1       this port wants the RAM bus
//  mem_a      out  ADDR_W  RAM byte address (registered)
//  ins_vld    out  1       one-cycle pulse: ins_out valid
//  ins_out    out  32      fetched instruction word
// BEHAVIOUR
//  Reset: state=IDLE; bus_req=0, mem_a=0, ins_vld=0, ins_out=0, byte counter=0.
//  rdy=0: no state, counter, output or cache update (the top-level also stalls the RAM).
//  FSM states:
//   IDLE: accept at edge when req=1 & flush=0; bus_req<=1 -> WAIT_GNT.
//   WAIT_GNT: on bus_gnt=1, mem_a<=addr, cnt<=0 -> READ.
//   READ: each edge mem_a<=mem_a+1, cnt<=cnt+1 while cnt<3.
//         Byte k on mem_din one cycle after mem_a=addr+k; captured into ins_out[8k+7:8k].
//         Capturing byte3 -> DONE, bus_req<=0, ins_vld<=1.
//   DONE: ins_vld=1 for exactly this cycle; req ignored; next edge -> IDLE, ins_vld<=0.
//  Latency with immediate grant: grant edge G; ins_vld high during the cycle after edge G+5.
//  Bytes are never reordered: ins_out = {b3,b2,b1,b0}, bk=RAM[addr+k]. mem_a wraps modulo 2^ADDR_W.
//  bus_gnt is sampled only in WAIT_GNT. Once granted, the bus is held until DONE; gnt drops in READ are protocol errors (assert).
//  flush: highest priority except rst. At edge with flush=1 in any state -> IDLE.
//   bus_req<=0, ins_vld<=0, partial bytes discarded, no cache fill.
//   flush in the same cycle as an accept: flush wins, nothing accepted.
//  addr change while busy without flush: illegal (assert). addr[1:0]!=0: illegal (assert); bytes fetched from addr as-is.
//  rst mid-operation: aborts like flush; additionally clears all outputs and, with I-cache, all valid bits.
// CONFIGURATION
//  Macro IFETCH_ICACHE_EN. Without it there is no cache; every request goes through the bus as above.
//  With it, a direct-mapped cache is added: index=addr[2+:log2(ICACHE_LINES)], tag=upper address bits, plus a valid bit.
//   IDLE and accept with hit: no bus_req; next edge -> DONE with ins_out=line data (ins_vld one cycle after accept edge).
//   Miss: normal bus fetch; on byte3 capture, the line is written (valid=1).
//   flush never invalidates lines; only rst clears the valid bits.
// STRUCTURE
//  Shared def.v: FSM state encodings (IFP_IDLE/WAIT_GNT/READ/DONE), `HIGH/`LOW.
//  Sub-module ifetch_icache: tag/valid/data arrays.
//   Lookup is combinational; the write port is synchronous.
//   Instantiated only under IFETCH_ICACHE_EN.
// TESTING
//  1 RAM[0x100..0x103]=13 05 A0 00, req addr=0x100, gnt tied 1
//    -> mem_a 0x100..0x103 on successive cycles; ins_vld 1 cycle, ins_out=0x00A00513.
//  2 bus_gnt held 0 for 7 cycles after accept -> bus_req=1, mem_a unchanged; timing from 1 resumes at the grant edge.
//  3 flush at 2nd READ cycle -> IDLE next edge, no ins_vld.
//    A new req at 0x200 then returns RAM[0x200..0x203] correctly.
//  4 req+flush same edge in IDLE -> not accepted, bus_req stays 0.
//    rst mid-READ -> all outputs 0 next cycle.
//  5 rdy=0 for 3 cycles mid-READ -> mem_a/cnt frozen; final word identical to the no-stall case.
//  6 (IFETCH_ICACHE_EN) fetch 0x100 twice -> 2nd ins_vld one cycle after accept, no bus_req.
//    Fetch 0x100+4*ICACHE_LINES then 0x100 -> the conflict evicts the line, so the second 0x100 fetch is a miss.

Source files
------------

// File: rtl/ifetch_mem_port_pkg.sv
// Shared definitions for the instruction-fetch memory port: FSM encodings and byte-step helpers.
package ifetch_mem_port_pkg;

  typedef logic [1:0] ifp_state_t;

  localparam ifp_state_t IfpIdle    = 2'd0;
  localparam ifp_state_t IfpWaitGnt = 2'd1;
  localparam ifp_state_t IfpRead    = 2'd2;
  localparam ifp_state_t IfpDone    = 2'd3;

  // Counter value at which the last address has been issued, and at which byte3 is on mem_din.
  localparam logic [2:0] LastAddrStep = 3'd3;
  localparam logic [2:0] LastByteStep = 3'd4;

  // mem_din lags mem_a by one cycle, so step k carries byte k-1.
  function automatic logic [1:0] byte_lane(input logic [2:0] step);
    return 2'(step - 3'd1);
  endfunction

endpackage

// File: rtl/ifetch_mem_port_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line: combinational lookup,
// synchronous write, valid bits cleared only by reset.
module ifetch_mem_port_icache #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINES  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] rd_word_i,
  output logic              hit_o,
  output logic [31:0]       rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-3:0] wr_word_i,
  input  logic [31:0]       wr_data_i
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = ADDR_W - 2 - IdxW;

  logic [LINES-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IdxW-1:0] rd_idx, wr_idx;
  logic [TagW-1:0] rd_tag, wr_tag;

  assign rd_idx = rd_word_i[IdxW-1:0];
  assign rd_tag = rd_word_i[ADDR_W-3 -: TagW];
  assign wr_idx = wr_word_i[IdxW-1:0];
  assign wr_tag = wr_word_i[ADDR_W-3 -: TagW];

  assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/ifetch_mem_port.sv
// Instruction-fetch memory port: reads a word as 4 little-endian bytes over the shared RAM bus.
// Optional direct-mapped I-cache enabled by defining IFETCH_ICACHE_EN.
module ifetch_mem_port
  import ifetch_mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  input  logic              bus_gnt_i,
  input  logic [7:0]        mem_din_i,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              ins_vld_o,
  output logic [31:0]       ins_out_o
);

  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_chk
    $error("ICACHE_LINES must be a power of 2");
  end

  ifp_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              ins_vld_q, ins_vld_d;
  logic [31:0]       ins_out_q, ins_out_d;
  logic              hit;
  logic [31:0]       hit_data;
  logic              fill;

`ifdef IFETCH_ICACHE_EN
  ifetch_mem_port_icache #(
    .ADDR_W (ADDR_W),
    .LINES  (ICACHE_LINES)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .rd_word_i (addr_i[ADDR_W-1:2]),
    .hit_o     (hit),
    .rd_data_o (hit_data),
    .wr_en_i   (fill),
    .wr_word_i (addr_i[ADDR_W-1:2]),
    .wr_data_i ({mem_din_i, ins_out_q[23:0]})
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_req_d = bus_req_q;
    mem_a_d   = mem_a_q;
    ins_vld_d = ins_vld_q;
    ins_out_d = ins_out_q;
    fill      = 1'b0;
    if (rdy_i) begin
      if (flush_i) begin
        state_d   = IfpIdle;
        bus_req_d = 1'b0;
        ins_vld_d = 1'b0;
      end else begin
        unique case (state_q)
          IfpIdle: begin
            if (req_i) begin
              if (hit) begin
                state_d   = IfpDone;
                ins_vld_d = 1'b1;
                ins_out_d = hit_data;
              end else begin
                state_d   = IfpWaitGnt;
                bus_req_d = 1'b1;
              end
            end
          end
          IfpWaitGnt: begin
            if (bus_gnt_i) begin
              state_d = IfpRead;
              mem_a_d = addr_i;
              cnt_d   = '0;
            end
          end
          IfpRead: begin
            if (cnt_q < LastAddrStep) begin
              mem_a_d = mem_a_q + ADDR_W'(1);
            end
            if (cnt_q != 3'd0) begin
              ins_out_d[{byte_lane(cnt_q), 3'b000} +: 8] = mem_din_i;
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LastByteStep) begin
              state_d   = IfpDone;
              bus_req_d = 1'b0;
              ins_vld_d = 1'b1;
              fill      = 1'b1;
            end
          end
          IfpDone: begin
            state_d   = IfpIdle;
            ins_vld_d = 1'b0;
          end
          default: state_d = IfpIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IfpIdle;
      cnt_q     <= '0;
      bus_req_q <= 1'b0;
      mem_a_q   <= '0;
      ins_vld_q <= 1'b0;
      ins_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_req_q <= bus_req_d;
      mem_a_q   <= mem_a_d;
      ins_vld_q <= ins_vld_d;
      ins_out_q <= ins_out_d;
    end
  end

  assign bus_req_o = bus_req_q;
  assign mem_a_o   = mem_a_q;
  assign ins_vld_o = ins_vld_q;
  assign ins_out_o = ins_out_q;

  // Protocol checks on the fetch stage and the arbiter.
  logic busy;
  assign busy = (state_q == IfpWaitGnt) || (state_q == IfpRead);

  ap_gnt_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == IfpRead && rdy_i && !flush_i) |-> bus_gnt_i);
  ap_addr_stable: assert property (@(posedge clk) disable iff (rst)
    (busy && !flush_i) |-> $stable(addr_i));
  ap_addr_aligned: assert property (@(posedge clk) disable iff (rst)
    (state_q == IfpIdle && rdy_i && req_i && !flush_i) |-> (addr_i[1:0] == 2'b00));

endmodule

// File: tb/tb_ifetch_mem_port.sv
// Self-checking bench for ifetch_mem_port: transaction-level reference model plus directed tests.
// Define IFETCH_ICACHE_EN to also exercise the I-cache.
module tb_ifetch_mem_port;

  localparam int unsigned Lines = 64;
  localparam int PhIdle = 0, PhWait = 1, PhRead = 2, PhDone = 3;

  logic        clk, rst, rdy, req, flush, gnt;
  logic [31:0] addr;
  logic [7:0]  mem_din;
  logic        bus_req, ins_vld;
  logic [31:0] mem_a, ins_out;

  logic [7:0]  ram [4096];
  int          checks, errors;

  ifetch_mem_port #(
    .ADDR_W       (32),
    .ICACHE_LINES (Lines)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy_i     (rdy),
    .req_i     (req),
    .addr_i    (addr),
    .flush_i   (flush),
    .bus_gnt_i (gnt),
    .mem_din_i (mem_din),
    .bus_req_o (bus_req),
    .mem_a_o   (mem_a),
    .ins_vld_o (ins_vld),
    .ins_out_o (ins_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM: data for the address seen at an edge appears after that edge; stalls with rdy.
  always @(posedge clk) if (rdy) mem_din <= ram[mem_a[11:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 1; a2 = a + 2; a3 = a + 3;
    return {ram[a3[11:0]], ram[a2[11:0]], ram[a1[11:0]], ram[a[11:0]]};
  endfunction

  // Reference model: phase of the current request and edges counted since the grant.
  int          m_ph, m_steps;
  logic        m_live, m_breq, m_vld, m_known;
  logic [31:0] m_base, m_mem_a, m_out;
`ifdef IFETCH_ICACHE_EN
  logic        c_valid [Lines];
  logic [31:0] c_tag   [Lines];
  logic [31:0] c_data  [Lines];
`endif

  function automatic logic model_hit(input logic [31:0] a);
`ifdef IFETCH_ICACHE_EN
    return c_valid[(a / 4) % Lines] && (c_tag[(a / 4) % Lines] == a / (4 * Lines));
`else
    return (a != a);
`endif
  endfunction

  initial m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_ph = PhIdle; m_breq = 1'b0; m_mem_a = '0;
      m_vld = 1'b0; m_out = '0; m_known = 1'b1;
`ifdef IFETCH_ICACHE_EN
      for (int i = 0; i < Lines; i++) c_valid[i] = 1'b0;
`endif
    end else if (rdy && m_live) begin
      m_vld = 1'b0;
      if (flush) begin
        m_ph = PhIdle; m_breq = 1'b0;
      end else begin
        case (m_ph)
          PhIdle: if (req) begin
            if (model_hit(addr)) begin
`ifdef IFETCH_ICACHE_EN
              m_out = c_data[(addr / 4) % Lines];
`endif
              m_vld = 1'b1; m_known = 1'b1; m_ph = PhDone;
            end else begin
              m_breq = 1'b1; m_ph = PhWait;
            end
          end
          PhWait: if (gnt) begin
            m_base = addr; m_mem_a = addr; m_steps = 0; m_known = 1'b0; m_ph = PhRead;
          end
          PhRead: begin
            m_steps++;
            m_mem_a = m_base + ((m_steps < 3) ? m_steps : 3);
            if (m_steps == 5) begin
              m_vld = 1'b1; m_out = ram_word(m_base); m_known = 1'b1;
              m_breq = 1'b0; m_ph = PhDone;
`ifdef IFETCH_ICACHE_EN
              c_valid[(m_base / 4) % Lines] = 1'b1;
              c_tag[(m_base / 4) % Lines]   = m_base / (4 * Lines);
              c_data[(m_base / 4) % Lines]  = m_out;
`endif
            end
          end
          default: m_ph = PhIdle;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_bus_req", 32'(bus_req), 32'(m_breq));
      chk("m_ins_vld", 32'(ins_vld), 32'(m_vld));
      chk("m_mem_a", mem_a, m_mem_a);
      if (m_known) chk("m_ins_out", ins_out, m_out);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_vld(input int max, output int cyc);
    cyc = 0;
    while (!ins_vld && cyc < max) begin
      step(1);
      cyc++;
    end
    if (!ins_vld) chk("vld_timeout", 32'(ins_vld), 32'd1);
  endtask

  task automatic do_reset();
    req = 1'b0; flush = 1'b0; rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  int c;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; rdy = 1'b1; req = 1'b0; flush = 1'b0; gnt = 1'b0; addr = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 7 + 3);
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'hA0; ram[12'h103] = 8'h00;
    ram[12'h200] = 8'hDE; ram[12'h201] = 8'hAD; ram[12'h202] = 8'hBE; ram[12'h203] = 8'hEF;
    step(2);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_ins_vld", 32'(ins_vld), 32'd0);
    chk("rst_ins_out", ins_out, 32'd0);
    rst = 1'b0;
    step(1);

    // 1: immediate grant, address walk and latency
    gnt = 1'b1; req = 1'b1; addr = 32'h100;
    step(1);
    chk("t1_bus_req", 32'(bus_req), 32'd1);
    step(1); chk("t1_a0", mem_a, 32'h100);
    step(1); chk("t1_a1", mem_a, 32'h101);
    step(1); chk("t1_a2", mem_a, 32'h102);
    step(1); chk("t1_a3", mem_a, 32'h103);
    step(1); chk("t1_vld_early", 32'(ins_vld), 32'd0);
    step(1);
    chk("t1_vld", 32'(ins_vld), 32'd1);
    chk("t1_word", ins_out, 32'h00A00513);
    req = 1'b0;
    step(1);
    chk("t1_vld_pulse", 32'(ins_vld), 32'd0);

    // 2: grant withheld for 7 cycles
    gnt = 1'b0; req = 1'b1; addr = 32'h104;
    step(8);
    chk("t2_bus_req_wait", 32'(bus_req), 32'd1);
    chk("t2_mem_a_hold", mem_a, 32'h103);
    gnt = 1'b1;
    step(1);
    chk("t2_a0", mem_a, 32'h104);
    wait_vld(10, c);
    chk("t2_latency", 32'(c), 32'd5);
    chk("t2_word", ins_out, 32'h342D261F);
    req = 1'b0;
    step(1);

    // 3: flush in the second READ cycle, then a clean fetch
    do_reset();
    req = 1'b1; addr = 32'h100;
    step(3);
    flush = 1'b1;
    step(1);
    flush = 1'b0; req = 1'b0;
    chk("t3_bus_req", 32'(bus_req), 32'd0);
    step(6);
    req = 1'b1; addr = 32'h200;
    wait_vld(12, c);
    chk("t3_latency", 32'(c), 32'd7);
    chk("t3_word", ins_out, 32'hEFBEADDE);
    req = 1'b0;
    step(1);

    // 4: request and flush on the same edge; reset mid-READ
    req = 1'b1; flush = 1'b1; addr = 32'h100;
    step(1);
    chk("t4_no_accept", 32'(bus_req), 32'd0);
    flush = 1'b0; req = 1'b0;
    step(1);
    req = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    chk("t4_rst_bus_req", 32'(bus_req), 32'd0);
    chk("t4_rst_mem_a", mem_a, 32'd0);
    chk("t4_rst_ins_vld", 32'(ins_vld), 32'd0);
    chk("t4_rst_ins_out", ins_out, 32'd0);
    rst = 1'b0; req = 1'b0;
    step(1);

    // 5: rdy stall mid-READ
    do_reset();
    req = 1'b1; addr = 32'h100;
    step(3);
    rdy = 1'b0;
    step(3);
    chk("t5_mem_a_frozen", mem_a, 32'h101);
    rdy = 1'b1;
    wait_vld(10, c);
    chk("t5_latency", 32'(c), 32'd4);
    chk("t5_word", ins_out, 32'h00A00513);
    req = 1'b0;
    step(1);

`ifdef IFETCH_ICACHE_EN
    // 6: hit, then a conflicting line evicts it
    do_reset();
    req = 1'b1; addr = 32'h100;
    wait_vld(12, c);
    chk("t6_miss_latency", 32'(c), 32'd7);
    req = 1'b0;
    step(1);
    req = 1'b1;
    step(1);
    chk("t6_hit_vld", 32'(ins_vld), 32'd1);
    chk("t6_hit_bus_req", 32'(bus_req), 32'd0);
    chk("t6_hit_word", ins_out, 32'h00A00513);
    req = 1'b0;
    step(1);
    req = 1'b1; addr = 32'h100 + 4 * Lines;
    wait_vld(12, c);
    chk("t6_conflict_word", ins_out, 32'hEFBEADDE);
    req = 1'b0;
    step(1);
    req = 1'b1; addr = 32'h100;
    step(1);
    chk("t6_evicted_bus_req", 32'(bus_req), 32'd1);
    wait_vld(12, c);
    chk("t6_refetch_word", ins_out, 32'h00A00513);
    req = 1'b0;
    step(1);
`endif

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
